// File: rtl/reg_file_bank.sv
// Parametrised 2-read/1-write register bank with registered reads and a post-reset
// initialisation sequencer. Optional write-through forwarding: define REGFILE_BYPASS_EN.
module reg_file_bank #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int INIT_MODE = 1,
    parameter int R0_ZERO   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data_to_write,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     init_idx_q, init_idx_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   data1_q, data1_d;
    logic [DATA_W-1:0]   data2_q, data2_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   init_addr;

    assign init_addr = init_idx_q[ADDR_W-1:0];

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ready_d    = ready_q;
        data1_d    = '0;
        data2_d    = '0;
        wr_en      = 1'b0;
        wr_addr    = rd;
        wr_data    = data_to_write;

        case (state_q)
            ST_INIT: begin
                // The sequencer owns the write port; reg_write is ignored and reads stay 0.
                wr_en      = 1'b1;
                wr_addr    = init_addr;
                wr_data    = (INIT_MODE == 1) ? DATA_W'(init_addr) : '0;
                if (R0_ZERO != 0 && init_addr == '0) begin
                    wr_data = '0;
                end
                init_idx_d = init_idx_q + (ADDR_W + 1)'(1);
                if (init_idx_q == (ADDR_W + 1)'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end

            ST_RUN: begin
                wr_en   = reg_write && !(R0_ZERO != 0 && rd == '0);
                data1_d = regs_q[rs];
                data2_d = regs_q[rt];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && wr_addr == rs) data1_d = wr_data;
                if (wr_en && wr_addr == rt) data2_d = wr_data;
`endif
                // Hard-wired zero wins over both storage and forwarding.
                if (R0_ZERO != 0 && rs == '0) data1_d = '0;
                if (R0_ZERO != 0 && rt == '0) data2_d = '0;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
            data1_q    <= '0;
            data2_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ready_q    <= ready_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
        end
    end

    // NOTE: storage has no reset term; the sequencer rewrites every entry after reset.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign data1 = data1_q;
    assign data2 = data2_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench for reg_file_bank: two instances (R0_ZERO=0 and 1) driven in parallel
// and compared every edge against an array-based model of the bank's behaviour.
module tb_reg_file_bank;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [2:0]  rs, rt, rd;
    logic [15:0] data_to_write;
    logic [15:0] a_data1, a_data2, b_data1, b_data2;
    logic        a_ready, b_ready;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [15:0] m_a [8];
    logic [15:0] m_b [8];
    bit          m_run;
    int          m_cnt;
    logic [15:0] ea1, ea2, eb1, eb2;
    logic        e_ready;

    always #5 clk = ~clk;

    reg_file_bank #(.DATA_W(16), .ADDR_W(3), .INIT_MODE(1), .R0_ZERO(0)) dut_a (
        .clock(clk), .reset(reset), .reg_write(reg_write),
        .rs(rs), .rt(rt), .rd(rd), .data_to_write(data_to_write),
        .data1(a_data1), .data2(a_data2), .ready(a_ready)
    );

    reg_file_bank #(.DATA_W(16), .ADDR_W(3), .INIT_MODE(1), .R0_ZERO(1)) dut_b (
        .clock(clk), .reset(reset), .reg_write(reg_write),
        .rs(rs), .rt(rt), .rd(rd), .data_to_write(data_to_write),
        .data1(b_data1), .data2(b_data2), .ready(b_ready)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the model, then compare both instances.
    task automatic step(input bit rst, input bit we, input int rsv, input int rtv,
                        input int rdv, input logic [15:0] wd);
        reset         = rst;
        reg_write     = we;
        rs            = 3'(rsv);
        rt            = 3'(rtv);
        rd            = 3'(rdv);
        data_to_write = wd;

        if (rst) begin
            m_run = 1'b0; m_cnt = 0; e_ready = 1'b0;
            ea1 = '0; ea2 = '0; eb1 = '0; eb2 = '0;
        end else if (!m_run) begin
            m_a[m_cnt] = 16'(m_cnt);
            m_b[m_cnt] = 16'(m_cnt);
            m_cnt++;
            if (m_cnt == 8) begin
                m_run = 1'b1; e_ready = 1'b1;
            end
            ea1 = '0; ea2 = '0; eb1 = '0; eb2 = '0;
        end else begin
            ea1 = (BYP && we && rdv == rsv) ? wd : m_a[rsv];
            ea2 = (BYP && we && rdv == rtv) ? wd : m_a[rtv];
            eb1 = (rsv == 0) ? 16'h0 : (BYP && we && rdv == rsv) ? wd : m_b[rsv];
            eb2 = (rtv == 0) ? 16'h0 : (BYP && we && rdv == rtv) ? wd : m_b[rtv];
            if (we) m_a[rdv] = wd;
            if (we && rdv != 0) m_b[rdv] = wd;
        end

        @(posedge clk);
        #1;
        check("a_data1", a_data1, ea1);
        check("a_data2", a_data2, ea2);
        check("a_ready", 16'(a_ready), 16'(e_ready));
        check("b_data1", b_data1, eb1);
        check("b_data2", b_data2, eb2);
        check("b_ready", 16'(b_ready), 16'(e_ready));
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; rs = '0; rt = '0; rd = '0; data_to_write = '0;
        m_run = 1'b0; m_cnt = 0; e_ready = 1'b0;
        ea1 = '0; ea2 = '0; eb1 = '0; eb2 = '0;

        // Reset held for two edges
        step(1, 0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 0, 16'h0);
        check("rst_ready", 16'(a_ready), 16'h0);

        // Initialisation while attempting a write to r2 that must be ignored
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2, 2, 2, 16'hAAAA);
            if (i < 7) check("init_not_ready", 16'(a_ready), 16'h0);
        end
        check("init_ready", 16'(a_ready), 16'h1);

        // Initial contents
        step(0, 0, 5, 7, 0, 16'h0);
        check("init_r5", a_data1, 16'd5);
        check("init_r7", a_data2, 16'd7);
        step(0, 0, 2, 2, 0, 16'h0);
        check("init_write_ignored", a_data1, 16'd2);

        // Write then read on both ports
        step(0, 1, 0, 0, 3, 16'hBEEF);
        step(0, 0, 3, 3, 0, 16'h0);
        check("beef_data1", a_data1, 16'hBEEF);
        check("beef_data2", a_data2, 16'hBEEF);

        // Same-edge collision
        step(0, 1, 4, 5, 4, 16'h1234);
        check("collide_now", a_data1, BYP ? 16'h1234 : 16'd4);
        step(0, 0, 4, 4, 0, 16'h0);
        check("collide_next", a_data1, 16'h1234);

        // Register 0 hard-wired zero in dut_b, then a write to r1 still lands
        step(0, 1, 0, 0, 0, 16'hFFFF);
        check("r0_b_same_edge", b_data1, 16'h0);
        step(0, 1, 0, 1, 1, 16'h0F0F);
        check("r0_b_read", b_data1, 16'h0);
        check("r0_a_read", a_data1, 16'hFFFF);
        step(0, 0, 0, 1, 0, 16'h0);
        check("r1_b_write", b_data2, 16'h0F0F);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 16'($urandom));
        end

        // Let any random reset finish its sequence
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 16'h0);

        // Mid-operation reset discards the in-flight write and reinitialises
        step(0, 1, 0, 0, 6, 16'h5555);
        step(1, 1, 6, 6, 6, 16'h7777);
        check("midrst_ready", 16'(a_ready), 16'h0);
        check("midrst_data1", a_data1, 16'h0);
        check("midrst_data2", a_data2, 16'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 6, 6, 0, 16'h0);
        check("midrst_ready_again", 16'(a_ready), 16'h1);
        step(0, 0, 6, 6, 0, 16'h0);
        check("midrst_r6", a_data1, 16'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
